jtopl_acc_seq: RTL and testbench
================================

# jtopl_acc_seq

Sequencer for the operator-output accumulator. It tracks the 18-slot operator frame and decides which slots are summed into the channel mix, from the per-channel connection bits, rhythm mode and a channel mute mask. It drives the accumulator's `sum_en` and `zero` inputs, delayed to match the operator pipeline latency. It also flags when a new output sample becomes valid.

## Interface
- `LAT`, default 3: operator pipeline latency in `cenop` ticks, from slot issue to `op_result` valid; legal range 1..15.
- `rst`  in  1  synchronous, active-high reset.
- `clk`  in  1  system clock.
- `cenop`  in  1  operator clock enable; all state advances only when high, except `sample`.
- `con`  in  9  per-channel connection bit; 1 = additive, 0 = FM.
- `rhy_en`  in  1  rhythm mode enable.
- `ch_mute`  in  9  per-channel mute; 1 = channel never summed.
- `slot`  out  5  current issue slot, 0..17.
- `sum_en`  out  1  accumulator add enable, aligned to `op_result`.
- `zero`  out  1  accumulator restart, aligned to `op_result`.
- `sample`  out  1  one-`clk` pulse; the accumulator output has just been updated.

## Operation
- **Slot counter**
  - On `cenop`, `slot` increments modulo 18; 17 wraps to 0.
- **Slot decode**, group g = slot/6, i = slot%6:
  - i<3: modulator of channel 3g+i.
  - i≥3: carrier of channel 3g+i−3.
- **Config shadow**
  - `con`, `rhy_en` and `ch_mute` are copied into shadow registers on the `cenop` tick where `slot`==17.
  - The whole next frame (slots 0..17) decodes only from the shadows.
  - Mid-frame input changes have no effect until the next wrap.
- **Raw enable for the slot being issued**, channel c = decoded channel:
  - Muted channel (`ch_mute[c]`=1): 0.
  - Carrier: 1.
  - Modulator: `con[c]` (shadow).
  - With rhythm shadow=1: modulators of channels 7 and 8 give 1 regardless of `con` (HH/SD and TOM/TC are independent voices). Channel 6 (BD) follows the normal rule.
- **Raw first** = 1 exactly when `slot`==0.
- **Delay line**
  - LAT stages of {en, first, valid}, shifted on `cenop`.
  - Stage 0 captures {raw en, raw first, 1}.
  - `sum_en` = en & valid of the last stage; `zero` = first & valid of the last stage.
- **Sample pulse**
  - `sample` is registered every `clk`: `sample` <= `cenop` & `zero`.
  - It is high for exactly one `clk`, the cycle after the accumulator latches its new output.

## Timing
- **Reset values:** `slot`=0, all delay stages 0 (valid=0), shadows 0, `sum_en`=0, `zero`=0, `sample`=0.
- **Reset mid-frame:** applies fully on the next `clk`; no partial frame is ever marked `zero` afterwards.
- **Alignment:** while `slot` = (s+LAT) mod 18, `sum_en`/`zero` describe slot s.
- **After reset:**
  - `sum_en` and `zero` stay 0 for the first LAT `cenop` ticks.
  - The first `zero`=1 occurs when `slot`==LAT mod 18 on the first frame.
- **`zero` rate:** high on exactly one `cenop` tick per 18.
- **Idle `cenop`:** with `cenop` low, all outputs except `sample` hold, and `sample` is 0.
- **Simultaneous events:**
  - `rst` and `cenop` together: reset wins.
  - Config change on the wrap tick: the new value is captured and used for slot 0 of the next frame.

## Structure
- Shared package `jtopl_pkg` holds:
  - `SLOTS`=18.
  - `CHANNELS`=9.
  - The slot→channel/role decode as a function.
  - The rhythm channel indices 6/7/8.
- One sub-module, `jtopl_sh_en`: the parameterised LAT-deep shift register with clock enable and sync reset, carrying the {en, first, valid} bundle.
- The slot counter, shadows, decode and `sample` live in the top module.

## Test plan
1. **Reset, `cenop` every clk, LAT=3, `con`=0, `rhy_en`=0, `ch_mute`=0.**
   - `zero` first rises when `slot`==3, then every 18 ticks.
   - `sum_en` is high on 9 of each 18 ticks, exactly the carriers (issue slots 3–5, 9–11, 15–17).
2. **`con`=9'h1FF.**
   - `sum_en` high all 18 ticks per frame.
   - `con`=9'h001: slots 0,3,4,5,9,10,11,15,16,17 enabled.
3. **`ch_mute`=9'h100 with `con`=9'h1FF.**
   - Slots 14 and 17 are never enabled.
   - Then `rhy_en`=1, `con`=0, `ch_mute`=0: slots 13 and 14 are enabled in addition to all carriers.
4. **Change `con` from 0 to 9'h1FF while `slot`==8.**
   - No change in the delayed `sum_en` pattern for that frame.
   - The new pattern starts at the issue slot 0 after the wrap.
5. **`cenop` every 4th clk.**
   - `sample` is a single-clk pulse, once per 18 `cenop` ticks, on the clk after the `cenop`&`zero` tick.
   - All outputs hold between enables.
6. **`rst` asserted for 1 clk mid-frame (`slot`==10).**
   - `slot`=0 and `sum_en`=`zero`=0 on the next clk.
   - `zero` reappears only LAT ticks later.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared definitions for the operator-output accumulator sequencer:
// frame geometry, rhythm channel indices and the slot-to-channel decode.
package jtopl_pkg;

   localparam int unsigned SLOTS    = 18;
   localparam int unsigned CHANNELS = 9;

   localparam logic [4:0] FIRST_SLOT = 5'd0;
   localparam logic [4:0] LAST_SLOT  = 5'd17;

   // Rhythm voices: BD keeps the normal FM rule, the other two pair independent voices
   localparam logic [3:0] CH_BD     = 4'd6;
   localparam logic [3:0] CH_HH_SD  = 4'd7;
   localparam logic [3:0] CH_TOM_TC = 4'd8;

   typedef struct packed {
      logic [3:0] ch;
      logic       carrier;
   } slot_dec_t;

   typedef struct packed {
      logic en;
      logic first;
      logic valid;
   } acc_stage_t;

   function automatic slot_dec_t slot_decode(input logic [4:0] slot);
      slot_dec_t  dec;
      logic [4:0] idx;
      logic [3:0] base;
      if (slot >= 5'd12) begin
         idx  = slot - 5'd12;
         base = 4'd6;
      end else if (slot >= 5'd6) begin
         idx  = slot - 5'd6;
         base = 4'd3;
      end else begin
         idx  = slot;
         base = 4'd0;
      end
      dec.carrier = (idx >= 5'd3);
      dec.ch      = base + (dec.carrier ? (idx[3:0] - 4'd3) : idx[3:0]);
      return dec;
   endfunction

endpackage

// File: rtl/jtopl_sh_en.sv
// LAT-deep clock-enabled shift register carrying the {en, first, valid}
// bundle from slot issue to the accumulator input.
module jtopl_sh_en
   import jtopl_pkg::*;
#(
   parameter int unsigned LAT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cen_i,
   input  acc_stage_t d_i,
   output acc_stage_t q_o
);

   acc_stage_t stage_q [LAT];

   // Pipeline stages; reset empties the line so nothing stale reaches the accumulator
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(LAT); i++) begin
            stage_q[i] <= '0;
         end
      end else if (cen_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < int'(LAT); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end else begin
         for (int i = 0; i < int'(LAT); i++) begin
            stage_q[i] <= stage_q[i];
         end
      end
   end

   assign q_o = stage_q[LAT-1];

endmodule

// File: rtl/jtopl_acc_seq.sv
// Accumulator sequencer: walks the 18-slot frame, decides which operator
// outputs are summed and delays sum/restart to line up with op_result.
module jtopl_acc_seq
   import jtopl_pkg::*;
#(
   parameter int unsigned LAT = 3
) (
   input  logic       rst_i,
   input  logic       clk_i,
   input  logic       cenop_i,
   input  logic [8:0] con_i,
   input  logic       rhy_en_i,
   input  logic [8:0] ch_mute_i,
   output logic [4:0] slot_o,
   output logic       sum_en_o,
   output logic       zero_o,
   output logic       sample_o
);

   logic [4:0] slot_q;
   logic [4:0] slot_d;
   logic [8:0] con_q;
   logic [8:0] con_d;
   logic [8:0] mute_q;
   logic [8:0] mute_d;
   logic       rhy_q;
   logic       rhy_d;
   logic       sample_q;
   logic       sample_d;
   logic       wrap_s;

   slot_dec_t  dec_s;
   acc_stage_t raw_s;
   acc_stage_t last_s;

   // Slot advance and frame-boundary config capture
   always_comb begin
      wrap_s   = (slot_q == LAST_SLOT);
      slot_d   = slot_q;
      con_d    = con_q;
      mute_d   = mute_q;
      rhy_d    = rhy_q;
      if (cenop_i) begin
         if (wrap_s) begin
            slot_d = FIRST_SLOT;
            con_d  = con_i;
            mute_d = ch_mute_i;
            rhy_d  = rhy_en_i;
         end else begin
            slot_d = slot_q + 5'd1;
         end
      end else begin
         slot_d = slot_q;
      end
      sample_d = cenop_i & zero_o;
   end

   // Raw enable for the slot being issued, decoded only from the frame shadows
   always_comb begin
      dec_s       = slot_decode(slot_q);
      raw_s.valid = 1'b1;
      raw_s.first = (slot_q == FIRST_SLOT);
      if (mute_q[dec_s.ch]) begin
         raw_s.en = 1'b0;
      end else if (dec_s.carrier) begin
         raw_s.en = 1'b1;
      end else if (rhy_q && ((dec_s.ch == CH_HH_SD) || (dec_s.ch == CH_TOM_TC))) begin
         raw_s.en = 1'b1;
      end else begin
         raw_s.en = con_q[dec_s.ch];
      end
   end

   // Sequencer state; sample runs every clk so it is a single-cycle pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q   <= 5'd0;
         con_q    <= 9'd0;
         mute_q   <= 9'd0;
         rhy_q    <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         con_q    <= con_d;
         mute_q   <= mute_d;
         rhy_q    <= rhy_d;
         sample_q <= sample_d;
      end
   end

   jtopl_sh_en #(
      .LAT (LAT)
   ) u_sh_en (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cen_i (cenop_i),
      .d_i   (raw_s),
      .q_o   (last_s)
   );

   assign slot_o   = slot_q;
   assign sum_en_o = last_s.en & last_s.valid;
   assign zero_o   = last_s.first & last_s.valid;
   assign sample_o = sample_q;

endmodule

// File: tb/tb_jtopl_acc_seq.sv
// Scoreboard bench for jtopl_acc_seq: a frame-level reference model pushes
// the expected outputs per clk, a negedge monitor pops and compares.
module tb_jtopl_acc_seq;

   localparam int unsigned LAT = 3;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       cenop_i;
   logic [8:0] con_i;
   logic       rhy_en_i;
   logic [8:0] ch_mute_i;
   logic [4:0] slot_o;
   logic       sum_en_o;
   logic       zero_o;
   logic       sample_o;

   jtopl_acc_seq #(.LAT(LAT)) dut (
      .rst_i     (rst_i),
      .clk_i     (clk),
      .cenop_i   (cenop_i),
      .con_i     (con_i),
      .rhy_en_i  (rhy_en_i),
      .ch_mute_i (ch_mute_i),
      .slot_o    (slot_o),
      .sum_en_o  (sum_en_o),
      .zero_o    (zero_o),
      .sample_o  (sample_o)
   );

   always #5 clk = ~clk;

   typedef struct { bit en; bit first; } item_t;
   typedef struct { int slot; bit sum_en; bit zero; bit sample; } exp_t;

   item_t hist[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;

   int       m_slot   = 0;
   bit [8:0] sh_con   = 9'd0;
   bit [8:0] sh_mute  = 9'd0;
   bit       sh_rhy   = 1'b0;
   bit       m_sample = 1'b0;
   bit       m_sum_en = 1'b0;
   bit       m_zero   = 1'b0;

   task automatic cmp(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask

   // Which operators a frame sums, straight from channel roles
   function automatic bit raw_en(input int s);
      int ch;
      bit car;
      ch  = (s / 6) * 3 + (s % 6) % 3;
      car = (s % 6) >= 3;
      if (sh_mute[ch]) return 1'b0;
      if (car) return 1'b1;
      if (sh_rhy && (ch == 7 || ch == 8)) return 1'b1;
      return sh_con[ch];
   endfunction

   task automatic model_update(input bit cen, input bit r);
      if (r) begin
         m_slot = 0;
         hist.delete();
         sh_con = 9'd0; sh_mute = 9'd0; sh_rhy = 1'b0;
         m_sample = 1'b0;
      end else begin
         m_sample = cen && m_zero;
         if (cen) begin
            hist.push_back('{en: raw_en(m_slot), first: (m_slot == 0)});
            if (hist.size() > int'(LAT)) void'(hist.pop_front());
            if (m_slot == 17) begin
               sh_con = con_i; sh_mute = ch_mute_i; sh_rhy = rhy_en_i;
            end
            m_slot = (m_slot + 1) % 18;
         end
      end
      if (hist.size() == int'(LAT)) begin
         m_sum_en = hist[0].en;
         m_zero   = hist[0].first;
      end else begin
         m_sum_en = 1'b0;
         m_zero   = 1'b0;
      end
      exp_q.push_back('{slot: m_slot, sum_en: m_sum_en, zero: m_zero, sample: m_sample});
   endtask

   task automatic step(input bit cen, input bit r);
      cenop_i = cen;
      rst_i   = r;
      @(posedge clk);
      model_update(cen, r);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("slot",   int'(slot_o),   e.slot);
         cmp("sum_en", int'(sum_en_o), int'(e.sum_en));
         cmp("zero",   int'(zero_o),   int'(e.zero));
         cmp("sample", int'(sample_o), int'(e.sample));
      end
   end

   initial begin
      rst_i = 1'b1; cenop_i = 1'b0; con_i = 9'd0; rhy_en_i = 1'b0; ch_mute_i = 9'd0;
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      // plain FM frames: carriers only
      repeat (60) step(1'b1, 1'b0);
      con_i = 9'h1FF;
      repeat (40) step(1'b1, 1'b0);
      con_i = 9'h001;
      repeat (40) step(1'b1, 1'b0);
      con_i = 9'h1FF; ch_mute_i = 9'h100;
      repeat (40) step(1'b1, 1'b0);
      con_i = 9'h000; ch_mute_i = 9'h000; rhy_en_i = 1'b1;
      repeat (40) step(1'b1, 1'b0);
      rhy_en_i = 1'b0;
      repeat (40) step(1'b1, 1'b0);
      // config change mid-frame takes effect only after the wrap
      while (m_slot != 8) step(1'b1, 1'b0);
      con_i = 9'h1FF;
      repeat (40) step(1'b1, 1'b0);
      // sparse cenop
      for (int i = 0; i < 200; i++) step((i % 4) == 3, 1'b0);
      // reset mid-frame
      while (m_slot != 10) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (30) step(1'b1, 1'b0);
      // randomized enables, config and occasional reset
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) con_i = 9'($urandom);
         if ($urandom_range(0, 39) == 0) ch_mute_i = 9'($urandom) & 9'($urandom);
         if ($urandom_range(0, 59) == 0) rhy_en_i = 1'($urandom);
         step($urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      #1;
      cmp("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
